// File: rtl/lzrw1_pkg.sv
// rtl/lzrw1_pkg.sv - shared constants and FSM state type for the LZRW1 compressor
package lzrw1_pkg;

   localparam int          MIN_MATCH  = 3;
   localparam int          MAX_MATCH  = 16;
   localparam int          MAX_OFFSET = 4095;
   localparam int          BEAT_BYTES = 16;
   localparam logic [31:0] HASH_MUL   = 32'd40543;

   typedef enum logic [1:0] {
      LOAD,
      LOOKUP,
      EMIT,
      DONE
   } state_e;

endpackage

// File: rtl/lzrw1_hash.sv
// rtl/lzrw1_hash.sv - combinational 3-byte hash into the history table index
module lzrw1_hash
   import lzrw1_pkg::*;
#(
   parameter int TABLESIZE = 4096
) (
   input  logic [7:0]                   b0_i,
   input  logic [7:0]                   b1_i,
   input  logic [7:0]                   b2_i,
   output logic [$clog2(TABLESIZE)-1:0] idx_o
);
   localparam int IW = $clog2(TABLESIZE);

   logic [31:0] mix;

   assign mix = ({24'd0, b0_i} << 8) ^ ({24'd0, b1_i} << 4) ^ {24'd0, b2_i};

   // Truncating to IW bits is the power-of-two table mask.
   assign idx_o = IW'((mix * HASH_MUL) >> 4);

endmodule

// File: rtl/lzrw1_compressor.sv
// rtl/lzrw1_compressor.sv - single-shot LZRW1 compressor; define COMP_SVA_EN to compile in assertions
module lzrw1_compressor
   import lzrw1_pkg::*;
#(
   parameter int STRINGSIZE = 350,
   parameter int TABLESIZE  = 4096
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic                       valid,
   input  logic [BEAT_BYTES-1:0][7:0] CurByte,
   output logic                       Done,
   output logic [STRINGSIZE-1:0][7:0] compArray,
   output logic [STRINGSIZE-1:0]      controlWord
);
   localparam int PW = $clog2(STRINGSIZE + 1);
   localparam int AW = $clog2(STRINGSIZE);
   localparam int IW = $clog2(TABLESIZE);

   state_e          state_q, state_d;
   logic [PW-1:0]   total_q, total_d;
   logic [PW-1:0]   byte_ptr_q, byte_ptr_d;
   logic [PW-1:0]   comp_ptr_q, comp_ptr_d;
   logic [PW-1:0]   ctrl_ptr_q, ctrl_ptr_d;
   logic [IW-1:0]   h_q;
   logic [PW-1:0]   cand_q;
   logic            cand_vld_q;
   logic            have3_q;

   logic [7:0]      buffer_q [STRINGSIZE];
   logic [PW-1:0]   table_q  [TABLESIZE];
   logic [TABLESIZE-1:0] tvld_q;

   logic            load_we;
   logic            emit_en;
   logic            take_copy;
   logic            run;
   int              mlen;
   int              rem;
   logic [11:0]     offset;
   logic [7:0]      lit_byte;
   logic [7:0]      hb0, hb1, hb2;
   logic [IW-1:0]   hash_idx;

   function automatic logic [7:0] buf_at(input int idx);
      if (idx >= 0 && idx < STRINGSIZE) begin
         return buffer_q[AW'(idx)];
      end
      return 8'h00;
   endfunction

   always_comb begin
      hb0 = buf_at(int'(byte_ptr_q));
      hb1 = buf_at(int'(byte_ptr_q) + 1);
      hb2 = buf_at(int'(byte_ptr_q) + 2);
   end

   lzrw1_hash #(.TABLESIZE(TABLESIZE)) u_hash (
      .b0_i  (hb0),
      .b1_i  (hb1),
      .b2_i  (hb2),
      .idx_o (hash_idx)
   );

   // Match search against the candidate registered in LOOKUP.
   always_comb begin
      rem      = int'(total_q) - int'(byte_ptr_q);
      offset   = 12'(int'(byte_ptr_q) - int'(cand_q));
      lit_byte = buf_at(int'(byte_ptr_q));
      run      = 1'b1;
      mlen     = 0;
      for (int i = 0; i < MAX_MATCH; i++) begin
         if (run && (i < rem) &&
             (buf_at(int'(cand_q) + i) == buf_at(int'(byte_ptr_q) + i))) begin
            mlen = mlen + 1;
         end else begin
            run = 1'b0;
         end
      end
      take_copy = have3_q && cand_vld_q && (offset != 12'd0) &&
                  (int'(offset) <= MAX_OFFSET) && (mlen >= MIN_MATCH);
   end

   always_comb begin
      state_d    = state_q;
      total_d    = total_q;
      byte_ptr_d = byte_ptr_q;
      comp_ptr_d = comp_ptr_q;
      ctrl_ptr_d = ctrl_ptr_q;
      load_we    = 1'b0;
      emit_en    = 1'b0;
      case (state_q)
         LOAD: begin
            if (valid) begin
               load_we = 1'b1;
               if (int'(total_q) + BEAT_BYTES >= STRINGSIZE) begin
                  total_d = PW'(STRINGSIZE);
               end else begin
                  total_d = PW'(int'(total_q) + BEAT_BYTES);
               end
            end else if (total_q != '0) begin
               state_d = LOOKUP;
            end
         end
         LOOKUP: state_d = EMIT;
         EMIT: begin
            emit_en = 1'b1;
            if (take_copy) begin
               byte_ptr_d = PW'(int'(byte_ptr_q) + mlen);
               comp_ptr_d = PW'(int'(comp_ptr_q) + 2);
            end else begin
               byte_ptr_d = PW'(int'(byte_ptr_q) + 1);
               comp_ptr_d = PW'(int'(comp_ptr_q) + 1);
            end
            ctrl_ptr_d = PW'(int'(ctrl_ptr_q) + 1);
            state_d    = (int'(byte_ptr_d) >= int'(total_q)) ? DONE : LOOKUP;
         end
         DONE: state_d = DONE;
         default: state_d = LOAD;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q     <= LOAD;
         total_q     <= '0;
         byte_ptr_q  <= '0;
         comp_ptr_q  <= '0;
         ctrl_ptr_q  <= '0;
         h_q         <= '0;
         cand_q      <= '0;
         cand_vld_q  <= 1'b0;
         have3_q     <= 1'b0;
         tvld_q      <= '0;
         compArray   <= '0;
         controlWord <= '0;
      end else begin
         state_q    <= state_d;
         total_q    <= total_d;
         byte_ptr_q <= byte_ptr_d;
         comp_ptr_q <= comp_ptr_d;
         ctrl_ptr_q <= ctrl_ptr_d;
         if (state_q == LOOKUP) begin
            h_q        <= hash_idx;
            cand_q     <= table_q[hash_idx];
            cand_vld_q <= tvld_q[hash_idx];
            have3_q    <= (int'(byte_ptr_q) + MIN_MATCH <= int'(total_q));
         end
         if (emit_en) begin
            if (take_copy) begin
               if (int'(comp_ptr_q) + 1 < STRINGSIZE) begin
                  compArray[AW'(comp_ptr_q)]              <= {4'(mlen - 1), offset[11:8]};
                  compArray[AW'(int'(comp_ptr_q) + 1)]    <= offset[7:0];
               end
            end else if (int'(comp_ptr_q) < STRINGSIZE) begin
               compArray[AW'(comp_ptr_q)] <= lit_byte;
            end
            if (int'(ctrl_ptr_q) < STRINGSIZE) begin
               controlWord[AW'(ctrl_ptr_q)] <= take_copy;
            end
            if (have3_q) begin
               tvld_q[h_q] <= 1'b1;
            end
         end
      end
   end

   // Buffer and table contents are qualified by total_q and tvld_q, so they need no reset.
   always_ff @(posedge clock) begin
      if (load_we) begin
         for (int k = 0; k < BEAT_BYTES; k++) begin
            if (int'(total_q) + k < STRINGSIZE) begin
               buffer_q[AW'(int'(total_q) + k)] <= CurByte[k];
            end
         end
      end
      if (emit_en && have3_q) begin
         table_q[h_q] <= byte_ptr_q;
      end
   end

   assign Done = (state_q == DONE);

`ifdef COMP_SVA_EN
   a_copy_len: assert property (@(posedge clock) disable iff (!reset)
      (emit_en && take_copy) |-> ((mlen >= MIN_MATCH) && (offset != 12'd0)))
      else $error("copy item with short match or zero offset");

   a_ptr_adv: assert property (@(posedge clock) disable iff (!reset)
      emit_en |=> (int'(byte_ptr_q) ==
                   int'($past(byte_ptr_q)) + ($past(take_copy) ? $past(mlen) : 1)))
      else $error("byte pointer advanced by wrong amount");

   a_ctrl_bit: assert property (@(posedge clock) disable iff (!reset)
      emit_en |=> (controlWord[AW'($past(ctrl_ptr_q))] == $past(take_copy)))
      else $error("control bit does not match item type");

   a_lit_byte: assert property (@(posedge clock) disable iff (!reset)
      (emit_en && !take_copy) |=> (compArray[AW'($past(comp_ptr_q))] == $past(lit_byte)))
      else $error("literal byte differs from source byte");
`else
`endif

endmodule

// File: tb/tb_lzrw1_compressor.sv
// tb/tb_lzrw1_compressor.sv - directed self-checking bench for lzrw1_compressor
module tb_lzrw1_compressor;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic              rst16, v16, done16;
   logic [15:0][7:0]  cb16;
   logic [15:0][7:0]  ca16;
   logic [15:0]       cw16;

   logic              rst350, v350, done350;
   logic [15:0][7:0]  cb350;
   logic [349:0][7:0] ca350;
   logic [349:0]      cw350;

   logic [7:0]        txt [350];

   int checks = 0;
   int errors = 0;

   lzrw1_compressor #(.STRINGSIZE(16), .TABLESIZE(4096)) dut16 (
      .clock       (clk),
      .reset       (rst16),
      .valid       (v16),
      .CurByte     (cb16),
      .Done        (done16),
      .compArray   (ca16),
      .controlWord (cw16)
   );

   lzrw1_compressor #(.STRINGSIZE(350), .TABLESIZE(4096)) dut350 (
      .clock       (clk),
      .reset       (rst350),
      .valid       (v350),
      .CurByte     (cb350),
      .Done        (done350),
      .compArray   (ca350),
      .controlWord (cw350)
   );

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [127:0] str16(input string s);
      logic [15:0][7:0] v;
      v = '0;
      for (int i = 0; i < 16; i++) v[i] = s[i];
      return v;
   endfunction

   task automatic reset16();
      @(negedge clk);
      rst16 = 1'b0; v16 = 1'b0; cb16 = '0;
      repeat (2) @(negedge clk);
      rst16 = 1'b1;
   endtask

   task automatic reset350();
      @(negedge clk);
      rst350 = 1'b0; v350 = 1'b0; cb350 = '0;
      repeat (2) @(negedge clk);
      rst350 = 1'b1;
   endtask

   task automatic load16(input string s);
      @(negedge clk);
      v16 = 1'b1;
      cb16 = str16(s);
      @(negedge clk);
      v16 = 1'b0;
      cb16 = '0;
   endtask

   task automatic load350_str(input string s);
      @(negedge clk);
      v350 = 1'b1;
      cb350 = str16(s);
      @(negedge clk);
      v350 = 1'b0;
      cb350 = '0;
   endtask

   task automatic load_text();
      for (int b = 0; b < 22; b++) begin
         @(negedge clk);
         v350 = 1'b1;
         for (int k = 0; k < 16; k++) begin
            cb350[k] = (16 * b + k < 350) ? txt[16 * b + k] : 8'h00;
         end
      end
      @(negedge clk);
      v350 = 1'b0;
      cb350 = '0;
   endtask

   task automatic wait_done(input bit big, input int bound, input string tag);
      int n;
      n = 0;
      while (((big ? done350 : done16) == 1'b0) && n < bound) begin
         @(negedge clk);
         n++;
      end
      chk(tag, 128'(big ? done350 : done16), 128'd1);
   endtask

   task automatic decode_check();
      logic [7:0] out [$];
      logic [7:0] hi, lo;
      int p, item, len, off, bad, copies, miss;
      p = 0; item = 0; bad = 0; copies = 0; miss = 0;
      while (out.size() < 350 && p < 350 && item < 350 && bad == 0) begin
         if (cw350[item]) begin
            hi  = ca350[p];
            lo  = (p + 1 < 350) ? ca350[p + 1] : 8'h00;
            len = int'(hi[7:4]) + 1;
            off = {20'd0, hi[3:0], lo};
            if (off == 0 || off > out.size()) begin
               bad = 1;
            end else begin
               for (int j = 0; j < len; j++) out.push_back(out[out.size() - off]);
               copies++;
            end
            p += 2;
         end else begin
            out.push_back(ca350[p]);
            p++;
         end
         item++;
      end
      for (int i = 0; i < 350; i++) begin
         if (i >= out.size() || out[i] !== txt[i]) miss++;
      end
      chk("text_bad_offset", 128'(bad), 128'd0);
      chk("text_decoded_len", 128'(out.size()), 128'd350);
      chk("text_byte_miss", 128'(miss), 128'd0);
      chk("text_compressed", 128'(p < 350), 128'd1);
      chk("text_has_copy", 128'(copies > 0), 128'd1);
   endtask

   initial begin
      string ph;
      ph = "It was the best of times, it was the worst of times, it was the age of wisdom, it was the age of foolishness. ";
      for (int i = 0; i < 350; i++) txt[i] = ph[i % ph.len()];

      rst16 = 1'b0; v16 = 1'b0; cb16 = '0;
      rst350 = 1'b0; v350 = 1'b0; cb350 = '0;

      repeat (3) begin
         @(negedge clk);
         v16  = 1'($urandom);
         cb16 = {$urandom, $urandom, $urandom, $urandom};
      end
      chk("reset_done", 128'(done16), 128'd0);
      chk("reset_comp", ca16, 128'd0);
      chk("reset_ctrl", 128'(cw16), 128'd0);
      @(negedge clk);
      v16 = 1'b0; cb16 = '0;
      rst16 = 1'b1; rst350 = 1'b1;

      load16("ABCDEFGHIJKLMNOP");
      wait_done(1'b0, 34, "lit_done");
      chk("lit_comp", ca16, str16("ABCDEFGHIJKLMNOP"));
      chk("lit_ctrl", 128'(cw16), 128'd0);
      @(negedge clk);
      v16 = 1'b1;
      cb16 = {$urandom, $urandom, $urandom, $urandom};
      @(negedge clk);
      v16 = 1'b0;
      repeat (3) @(negedge clk);
      chk("done_sticky", 128'(done16), 128'd1);
      chk("done_hold_comp", ca16, str16("ABCDEFGHIJKLMNOP"));

      reset16();
      load16("abcabcabcabcabca");
      wait_done(1'b0, 34, "abc_done");
      chk("abc_comp", ca16, {88'd0, 40'h03C0636261});
      chk("abc_ctrl", 128'(cw16), 128'h0008);

      reset16();
      load16("aaaaaaaaaaaaaaaa");
      wait_done(1'b0, 34, "aaa_done");
      chk("aaa_comp", ca16, {104'd0, 24'h01E061});
      chk("aaa_ctrl", 128'(cw16), 128'h0002);

      load_text();
      wait_done(1'b1, 702, "text_done");
      decode_check();

      reset350();
      load_text();
      repeat (40) @(negedge clk);
      chk("mid_live", 128'(|ca350), 128'd1);
      rst350 = 1'b0;
      #1;
      chk("mid_rst_done", 128'(done350), 128'd0);
      chk("mid_rst_comp", 128'(|ca350), 128'd0);
      chk("mid_rst_ctrl", 128'(|cw350), 128'd0);
      v350 = 1'b0;
      repeat (2) @(negedge clk);
      rst350 = 1'b1;
      load350_str("ABCDEFGHIJKLMNOP");
      wait_done(1'b1, 34, "reload_done");
      chk("reload_head", ca350[15:0], str16("ABCDEFGHIJKLMNOP"));
      chk("reload_tail", 128'(|ca350[349:16]), 128'd0);
      chk("reload_ctrl", 128'(|cw350), 128'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/lzrw1_compressor.md
Name: lzrw1_compressor

Overview:
- Single-shot LZRW1 hardware compressor.
- Loads a byte string of up to STRINGSIZE bytes, 16 bytes per valid beat, into an internal buffer.
- Encodes the buffer as literal bytes and 2-byte copy items, selected through a hashed history table.
- Presents the complete compressed image and the per-item control bits as flat parallel outputs, then asserts Done. Sits between a host loader and downstream packing logic.

Parameters:
- STRINGSIZE, 350: input buffer capacity in bytes; also the size of compArray (bytes) and controlWord (bits).
- TABLESIZE, 4096: hash table entries; power of two.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- valid  in  1  high during load beats; each high cycle carries one 16-byte beat.
- CurByte  in  16x8  beat data; CurByte[0] is the earliest byte.
- Done  out  1  compression complete; sticky.
- compArray  out  STRINGSIZEx8  compressed bytes; compArray[0] is the first byte emitted.
- controlWord  out  STRINGSIZE  one bit per emitted item (0 = literal, 1 = copy); bit 0 is the first item.

Behaviour:
- Reset (reset=0):
  - Done, compArray, controlWord, bytePtr, compressPtr and controlPtr all clear to 0.
  - All table-entry valid bits clear.
  - FSM goes to LOAD.
  - A reset mid-operation aborts the run; a new load may start right after release.
- LOAD state:
  - Each cycle with valid=1 writes CurByte[k] to buffer[16*beat+k]; bytes beyond STRINGSIZE are dropped.
  - total = min(16*beats, STRINGSIZE).
  - First cycle with valid=0 after at least one beat: go to LOOKUP.
  - valid=0 with zero beats keeps the FSM in LOAD.
- LOOKUP state:
  - If bytePtr+3 <= total: h = (((b0<<8)^(b1<<4)^b2) * 40543 >> 4) & (TABLESIZE-1), where b0..b2 = buffer[bytePtr..bytePtr+2].
  - Register h, table[h] and its valid bit.
  - Go to EMIT.
- EMIT state:
  - cand = table[h]; offset = bytePtr - cand.
  - Match length L = count of consecutive equal bytes buffer[cand+i] == buffer[bytePtr+i]. L is capped at 16 and at total-bytePtr.
  - Copy is taken when the entry is valid, 1 <= offset <= 4095, and L >= 3.
  - Copy item:
    - Write {L-1 [3:0], offset[11:8]} then offset[7:0] at compArray[compressPtr] and compArray[compressPtr+1].
    - controlWord[controlPtr] = 1; compressPtr += 2; bytePtr += L.
  - Otherwise, literal item:
    - compArray[compressPtr] = buffer[bytePtr]; controlWord[controlPtr] = 0.
    - compressPtr += 1; bytePtr += 1.
  - controlPtr += 1 for every item.
  - table[h] = old bytePtr, valid = 1. Written only when 3 bytes were available; the tail bytes (fewer than 3 left) are always literals with no table write.
  - Next state: DONE if the new bytePtr >= total, else LOOKUP.
- DONE state:
  - Done = 1 from the cycle after the final EMIT.
  - Outputs hold; valid is ignored until reset.
- Outputs:
  - Unwritten compArray bytes and controlWord bits stay 0.
  - Outputs update live during compression and are final only when Done=1.
- Latency: 2 cycles per item. Done rises no later than 2*total+2 cycles after the end of LOAD.
- Width rules:
  - bytePtr, compressPtr and controlPtr are $clog2(STRINGSIZE+1) bits wide.
  - Offsets are 12-bit and computed unsigned.
  - Hash arithmetic is 32-bit, then masked.

Optional Feature:
- COMP_SVA_EN defined compiles in concurrent assertions, all sampled at clock and disabled under reset:
  - a copy item implies L >= 3 and offset > 0;
  - bytePtr advances by exactly L (copy) or 1 (literal);
  - the controlWord bit just written matches the item type;
  - a literal's compArray byte equals buffer[old bytePtr].
  - Violations report via $error.
- Undefined: no assertion code is present, and the RTL is functionally identical.

Decomposition:
- Package lzrw1_pkg:
  - constants MIN_MATCH=3, MAX_MATCH=16, MAX_OFFSET=4095, BEAT_BYTES=16, HASH_MUL=40543;
  - state enum {LOAD, LOOKUP, EMIT, DONE}.
- One sub-module lzrw1_hash: purely combinational; 3 bytes in, table index out; parameterised by TABLESIZE.

Test Plan:
- Reset asserted with random inputs -> Done=0, compArray all 0, controlWord all 0.
- STRINGSIZE=16, one beat "ABCDEFGHIJKLMNOP" -> 16 literals, compArray[0..15] = input, controlWord=0, Done high at most 34 cycles after valid falls.
- STRINGSIZE=16, "abcabcabcabcabca" -> items a,b,c then a copy: controlWord[3:0]=4'b1000, compArray[0..4] = 61 62 63 C0 03.
- STRINGSIZE=16, "aaaaaaaaaaaaaaaa" -> literal 'a' then copy L=15, offset 1: compArray[0..2] = 61 E0 01, controlWord[1:0]=2'b10.
- Reset pulsed during EMIT of the 350-byte run -> outputs clear immediately; a reload of "ABCDEFGHIJKLMNOP" then gives the literal-only result.
- 350-byte English text in 22 beats (last beat zero-padded) -> a software LZRW1 decoder over compArray/controlWord reproduces the input exactly; compressPtr < 350; with COMP_SVA_EN, zero assertion failures.
